// File: rtl/multicycle_sequencer.sv
// Multicycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP); optional PERF_COUNTERS_EN adds cycle/instret counters.
// Latency: 4 cycles ALU, 3 cycles branch/jump, 4-5 cycles load/store, plus any memory wait cycles.
// Backpressure: holds imem_req/dmem_req until the matching ready; watchdog traps after MEM_TIMEOUT wait cycles.
module multicycle_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TIMEOUT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        dec_memwrite,
  input  logic        dec_memtoreg,
  input  logic        dec_dobranch,
  input  logic        dec_dojump,
  input  logic [1:0]  dec_regwrite,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        irwrite,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [1:0]  rf_we,
  output logic        pc_en,
  output logic [1:0]  pc_sel,
  output logic        retire,
  output logic        trap,
  output logic [1:0]  trap_cause
`ifdef PERF_COUNTERS_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_JAL    = 6'b000011;

  localparam logic [TIMEOUT_W:0] TO_LIM = (TIMEOUT_W+1)'(MEM_TIMEOUT);

  state_t               state_q, state_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic [TIMEOUT_W:0]   wd_inc;
  logic [1:0]           cause_q, cause_d;
  logic [5:0]           op, funct;
  logic                 legal, waiting, timeout, is_mem, is_branch;
  logic                 unused_ok;

  assign op        = instr[31:26];
  assign funct     = instr[5:0];
  assign is_mem    = (op == OP_LW) || (op == OP_SW);
  assign is_branch = (op == OP_BEQ) || (op == OP_REGIMM);
  // The Decoder already folds zero into dec_dobranch; memtoreg only steers the datapath mux.
  assign unused_ok = ^{zero, dec_memtoreg, instr[25:6]};

  always_comb begin
    legal = 1'b0;
    case (op)
      OP_RTYPE: legal = funct inside {6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101011};
      OP_LW, OP_SW, OP_BEQ, OP_ADDIU, OP_J, OP_ORI, OP_LUI, OP_REGIMM, OP_JAL: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // Watchdog counts consecutive stalled cycles of the current memory handshake.
  assign waiting = ((state_q == S_FETCH) && !imem_ready) || ((state_q == S_MEM) && !dmem_ready);
  assign wd_inc  = {1'b0, wd_q} + {{TIMEOUT_W{1'b0}}, 1'b1};
  assign timeout = waiting && (MEM_TIMEOUT != 0) && (wd_inc == TO_LIM);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      wd_q    <= '0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      if ((state_d == S_TRAP) && (state_q != S_TRAP))
        cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cause_d    = 2'b00;
    imem_req   = 1'b0;
    irwrite    = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    rf_we      = 2'b00;
    pc_en      = 1'b0;
    pc_sel     = 2'b00;
    retire     = 1'b0;
    trap       = (state_q == S_TRAP);
    trap_cause = cause_q;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          irwrite = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_d = 2'b01;
        end
      end
      S_EXEC: begin
        if (dec_dojump) begin
          pc_en   = 1'b1;
          pc_sel  = 2'b10;
          rf_we   = (dec_regwrite == 2'b10) ? 2'b10 : 2'b00;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (is_branch) begin
          pc_en   = 1'b1;
          pc_sel  = dec_dobranch ? 2'b01 : 2'b00;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (is_mem) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec_memwrite;
        if (dmem_ready) begin
          if (op == OP_SW) begin
            pc_en   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end
      end
      S_WB: begin
        rf_we   = dec_regwrite;
        pc_en   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_TRAP;
    endcase

    if (waiting && (state_d == state_q))
      wd_d = (&wd_q) ? wd_q : wd_inc[TIMEOUT_W-1:0];
    else
      wd_d = '0;

    // Everything is forced quiet while reset is held, even before the first edge.
    if (!reset) begin
      imem_req   = 1'b0;
      irwrite    = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      rf_we      = 2'b00;
      pc_en      = 1'b0;
      pc_sel     = 2'b00;
      retire     = 1'b0;
      trap       = 1'b0;
      trap_cause = 2'b00;
    end
  end

`ifdef PERF_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_cnt   <= 32'd0;
      instret_cnt <= 32'd0;
    end else begin
      if (state_q != S_TRAP)
        cycle_cnt <= cycle_cnt + 32'd1;
      if (retire)
        instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: per-instruction observed trace summary vs arithmetic model.
module tb_multicycle_sequencer;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        zero, dec_memwrite, dec_memtoreg, dec_dobranch, dec_dojump;
  logic [1:0]  dec_regwrite;
  logic        imem_ready, dmem_ready;
  logic        imem_req, irwrite, dmem_req, dmem_we, pc_en, retire, trap;
  logic [1:0]  rf_we, pc_sel, trap_cause;
`ifdef PERF_COUNTERS_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  always #5 clk = ~clk;

  multicycle_sequencer #(.MEM_TIMEOUT(TO), .TIMEOUT_W(8)) dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero),
    .dec_memwrite(dec_memwrite), .dec_memtoreg(dec_memtoreg),
    .dec_dobranch(dec_dobranch), .dec_dojump(dec_dojump), .dec_regwrite(dec_regwrite),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .irwrite(irwrite), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .rf_we(rf_we), .pc_en(pc_en), .pc_sel(pc_sel), .retire(retire),
    .trap(trap), .trap_cause(trap_cause)
`ifdef PERF_COUNTERS_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;

  typedef enum int {K_ALU, K_LW, K_SW, K_BEQ, K_REGIMM, K_J, K_JAL, K_ILL} kind_t;

  typedef struct packed {
    logic [7:0] cycles;
    logic [7:0] imem_cyc;
    logic [7:0] irw;
    logic [7:0] dreq_cyc;
    logic [7:0] dwe_cyc;
    logic [7:0] rf_cyc;
    logic [1:0] rf_val;
    logic [7:0] pcen;
    logic [1:0] pcsel;
    logic [7:0] ret;
    logic       trapped;
    logic [1:0] cause;
    logic       bad;
  } obs_t;

  task automatic setup_instr(input kind_t k, input logic br);
    logic [5:0] functs [5];
    logic [5:0] iops [3];
    functs = '{6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101011};
    iops   = '{6'b001001, 6'b001101, 6'b001111};
    zero = 1'($urandom);
    dec_memwrite = 1'b0; dec_memtoreg = 1'b0; dec_dobranch = 1'b0;
    dec_dojump = 1'b0; dec_regwrite = 2'b00;
    case (k)
      K_ALU: begin
        if ($urandom_range(1, 0) == 1)
          instr = {6'b000000, 20'($urandom), functs[$urandom_range(4, 0)]};
        else
          instr = {iops[$urandom_range(2, 0)], 26'($urandom)};
        dec_regwrite = 2'b01;
      end
      K_LW:     begin instr = {6'b100011, 26'($urandom)}; dec_memtoreg = 1'b1; dec_regwrite = 2'b01; end
      K_SW:     begin instr = {6'b101011, 26'($urandom)}; dec_memwrite = 1'b1; end
      K_BEQ:    begin instr = {6'b000100, 26'($urandom)}; dec_dobranch = br; end
      K_REGIMM: begin instr = {6'b000001, 26'($urandom)}; dec_dobranch = br; end
      K_J:      begin instr = {6'b000010, 26'($urandom)}; dec_dojump = 1'b1; dec_dobranch = br; end
      K_JAL:    begin instr = {6'b000011, 26'($urandom)}; dec_dojump = 1'b1; dec_dobranch = br; dec_regwrite = 2'b10; end
      default: begin
        if (br) instr = {6'b111111, 26'($urandom)};
        else    instr = {6'b000000, 20'($urandom), 6'b000000};
      end
    endcase
  endtask

  // Expected per-instruction summary derived from the phase sequence and wait counts.
  function automatic obs_t expect_instr(input kind_t k, input int fw, input int mw, input logic br);
    obs_t e;
    int fetch;
    logic mem;
    e = '0;
    if (fw >= TO) begin
      e.cycles = 8'(TO + 1); e.imem_cyc = 8'(TO); e.trapped = 1'b1; e.cause = 2'b10;
      return e;
    end
    fetch = fw + 1;
    e.imem_cyc = 8'(fetch);
    e.irw = 8'd1;
    if (k == K_ILL) begin
      e.cycles = 8'(fetch + 2); e.trapped = 1'b1; e.cause = 2'b01;
      return e;
    end
    mem = (k == K_LW) || (k == K_SW);
    if (mem && mw >= TO) begin
      e.cycles = 8'(fetch + 2 + TO + 1);
      e.dreq_cyc = 8'(TO);
      e.dwe_cyc = (k == K_SW) ? 8'(TO) : 8'd0;
      e.trapped = 1'b1; e.cause = 2'b10;
      return e;
    end
    e.cycles = 8'(fetch + 2 + (mem ? mw + 1 : 0) + ((k == K_ALU || k == K_LW) ? 1 : 0));
    e.dreq_cyc = mem ? 8'(mw + 1) : 8'd0;
    e.dwe_cyc = (k == K_SW) ? 8'(mw + 1) : 8'd0;
    if (k == K_ALU || k == K_LW) begin e.rf_cyc = 8'd1; e.rf_val = 2'b01; end
    if (k == K_JAL) begin e.rf_cyc = 8'd1; e.rf_val = 2'b10; end
    e.pcen = 8'd1;
    if (k == K_J || k == K_JAL) e.pcsel = 2'b10;
    else if (k == K_BEQ || k == K_REGIMM) e.pcsel = br ? 2'b01 : 2'b00;
    else e.pcsel = 2'b00;
    e.ret = 8'd1;
    return e;
  endfunction

  task automatic run_instr(input int fw, input int mw, output obs_t o);
    int fseen = 0;
    int mseen = 0;
    int n = 0;
    logic done = 1'b0;
    o = '0;
    while (!done && n < 60) begin
      imem_ready = (fseen >= fw);
      dmem_ready = (mseen >= mw);
      #1;
      n++;
      if (imem_req) begin o.imem_cyc = o.imem_cyc + 8'd1; if (!imem_ready) fseen++; end
      if (irwrite) o.irw = o.irw + 8'd1;
      if (dmem_req) begin o.dreq_cyc = o.dreq_cyc + 8'd1; if (!dmem_ready) mseen++; end
      if (dmem_we) o.dwe_cyc = o.dwe_cyc + 8'd1;
      if (dmem_we && !dmem_req) o.bad = 1'b1;
      if (rf_we != 2'b00) begin o.rf_cyc = o.rf_cyc + 8'd1; o.rf_val = rf_we; end
      if (pc_en) begin o.pcen = o.pcen + 8'd1; o.pcsel = pc_sel; end
      if (retire) begin o.ret = o.ret + 8'd1; done = 1'b1; end
      if (trap) begin o.trapped = 1'b1; o.cause = trap_cause; done = 1'b1; end
      @(negedge clk);
    end
    o.cycles = 8'(n);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; instr = 32'd0; zero = 1'b0;
    dec_memwrite = 1'b0; dec_memtoreg = 1'b0; dec_dobranch = 1'b0; dec_dojump = 1'b0;
    dec_regwrite = 2'b00; imem_ready = 1'b1; dmem_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({imem_req, irwrite, dmem_req, dmem_we, rf_we, pc_en, pc_sel, retire, trap, trap_cause} !== 14'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0", {imem_req, irwrite, dmem_req, dmem_we, rf_we, pc_en, pc_sel, retire, trap, trap_cause});
    end
    @(negedge clk);
    imem_ready = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b1) begin failures++; $display("FAIL reset_fetch_req got=%b exp=1", imem_req); end
    checks++;
    if ({trap, trap_cause} !== 3'b000) begin failures++; $display("FAIL reset_trap got=%b exp=000", {trap, trap_cause}); end
    checks++;
    if ({irwrite, dmem_req, dmem_we, rf_we, pc_en, retire} !== 7'd0) begin
      failures++; $display("FAIL reset_strobes got=%b exp=0", {irwrite, dmem_req, dmem_we, rf_we, pc_en, retire});
    end
    @(negedge clk);
  endtask

  task automatic test_addu();
    obs_t o, e;
    do_reset();
    setup_instr(K_ALU, 1'b0);
    instr = {6'b000000, 20'h12345, 6'b100001};
    e = expect_instr(K_ALU, 0, 0, 1'b0);
    run_instr(0, 0, o);
    checks++;
    if (o !== e) begin failures++; $display("FAIL addu_trace got=%h exp=%h", o, e); end
  endtask

  task automatic test_load_store();
    obs_t o, e;
    do_reset();
    setup_instr(K_LW, 1'b0);
    e = expect_instr(K_LW, 0, 3, 1'b0);
    run_instr(0, 3, o);
    checks++;
    if (o !== e) begin failures++; $display("FAIL lw_wait3 got=%h exp=%h", o, e); end
    setup_instr(K_SW, 1'b0);
    e = expect_instr(K_SW, 0, 3, 1'b0);
    run_instr(0, 3, o);
    checks++;
    if (o !== e) begin failures++; $display("FAIL sw_wait3 got=%h exp=%h", o, e); end
  endtask

  task automatic test_branch_jump();
    obs_t o, e;
    kind_t ks [5];
    logic  bs [5];
    ks = '{K_BEQ, K_BEQ, K_REGIMM, K_J, K_JAL};
    bs = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      setup_instr(ks[i], bs[i]);
      e = expect_instr(ks[i], 0, 0, bs[i]);
      run_instr(0, 0, o);
      checks++;
      if (o !== e) begin failures++; $display("FAIL branch_jump_%0d got=%h exp=%h", i, o, e); end
    end
  endtask

  task automatic test_illegal();
    obs_t o, e;
    int strobes;
    for (int v = 0; v < 2; v++) begin
      do_reset();
      setup_instr(K_ILL, 1'(v));
      e = expect_instr(K_ILL, 1, 0, 1'(v));
      run_instr(1, 0, o);
      checks++;
      if (o !== e) begin failures++; $display("FAIL illegal_%0d got=%h exp=%h", v, o, e); end
      strobes = 0;
      for (int c = 0; c < 10; c++) begin
        imem_ready = 1'($urandom); dmem_ready = 1'($urandom);
        #1;
        if (imem_req || irwrite || dmem_req || dmem_we || pc_en || retire || rf_we != 2'b00) strobes++;
        if (!trap || trap_cause != 2'b01) strobes++;
        @(negedge clk);
      end
      checks++;
      if (strobes !== 0) begin failures++; $display("FAIL illegal_sticky_%0d got=%0d exp=0", v, strobes); end
    end
  endtask

  task automatic test_timeout();
    obs_t o, e;
    do_reset();
    setup_instr(K_ALU, 1'b0);
    e = expect_instr(K_ALU, 100, 0, 1'b0);
    run_instr(100, 0, o);
    checks++;
    if (o !== e) begin failures++; $display("FAIL imem_timeout got=%h exp=%h", o, e); end
    do_reset();
    setup_instr(K_LW, 1'b0);
    e = expect_instr(K_LW, 2, 100, 1'b0);
    run_instr(2, 100, o);
    checks++;
    if (o !== e) begin failures++; $display("FAIL dmem_timeout got=%h exp=%h", o, e); end
  endtask

  task automatic test_reset_mid_mem();
    int seen = 0;
    do_reset();
    setup_instr(K_SW, 1'b0);
    imem_ready = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 20 && seen < 2; i++) begin
      #1;
      if (dmem_we) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen !== 2) begin failures++; $display("FAIL mid_mem_reach got=%0d exp=2", seen); end
    reset = 1'b0;
    #1;
    checks++;
    if ({imem_req, irwrite, dmem_req, dmem_we, rf_we, pc_en, retire, trap} !== 8'd0) begin
      failures++; $display("FAIL mid_mem_during_reset got=%b exp=0", {imem_req, irwrite, dmem_req, dmem_we, rf_we, pc_en, retire, trap});
    end
    @(negedge clk);
    reset = 1'b1;
    imem_ready = 1'b0;
    #1;
    checks++;
    if ({dmem_req, dmem_we, retire, pc_en, imem_req} !== 5'b00001) begin
      failures++; $display("FAIL mid_mem_after_reset got=%b exp=00001", {dmem_req, dmem_we, retire, pc_en, imem_req});
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    obs_t o, e;
    kind_t k;
    int fw, mw;
    logic br;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      k  = kind_t'($urandom_range(6, 0));
      fw = $urandom_range(3, 0);
      mw = $urandom_range(3, 0);
      br = 1'($urandom);
      setup_instr(k, br);
      e = expect_instr(k, fw, mw, br);
      run_instr(fw, mw, o);
      checks++;
      if (o !== e) begin failures++; $display("FAIL b2b_%0d kind=%0d got=%h exp=%h", i, k, o, e); end
    end
  endtask

`ifdef PERF_COUNTERS_EN
  task automatic test_perf();
    obs_t o;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      setup_instr(K_ALU, 1'b0);
      run_instr(0, 0, o);
    end
    #1;
    checks++;
    if (instret_cnt !== 32'd10) begin failures++; $display("FAIL perf_instret got=%0d exp=10", instret_cnt); end
    checks++;
    if (cycle_cnt !== 32'd40) begin failures++; $display("FAIL perf_cycles got=%0d exp=40", cycle_cnt); end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_addu();
    test_load_store();
    test_branch_jump();
    test_illegal();
    test_timeout();
    test_reset_mid_mem();
    test_back_to_back();
`ifdef PERF_COUNTERS_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
